riscv_hazard_unit: RTL and testbench

Centralised hazard, forwarding and flush controller for the five-stage RISC-V pipeline (IF, ID, EX, MEM, WB). It keeps its own shadow copy of the control and register fields in flight in EX, MEM and WB. From those it generates load-use stalls, branch flushes, and EX-stage operand forwarding selects. It also adds a parametrised multi-cycle load latency freeze and saturating stall/flush performance counters, which the current pipeline top lacks.

---
 rtl/riscv_hazard_unit.sv | 150 +++++++++++++++
 tb/tb_riscv_hazard_unit.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_hazard_unit.sv
// Hazard, forwarding and flush controller for the 5-stage pipeline. Tracks EX/MEM/WB
// in shadow slots and adds a load-latency freeze plus saturating stall/flush counters.
module riscv_hazard_unit #(
    parameter int unsigned REG_AW       = 5,
    parameter int unsigned LOAD_LATENCY = 0,
    parameter int unsigned CNT_W        = 16
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              id_valid_i,
    input  logic [REG_AW-1:0] id_rs1_i,
    input  logic [REG_AW-1:0] id_rs2_i,
    input  logic              id_use_rs1_i,
    input  logic              id_use_rs2_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic              id_regwrite_i,
    input  logic              id_memread_i,
    input  logic              branch_taken_i,
    output logic              stall_if_id_o,
    output logic              freeze_o,
    output logic              flush_if_id_o,
    output logic              flush_id_ex_o,
    output logic              flush_ex_mem_o,
    output logic [1:0]        fwd_a_o,
    output logic [1:0]        fwd_b_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
);

    localparam logic [2:0] LoadLat = 3'(LOAD_LATENCY);

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              regwrite;
        logic              memread;
    } slot_t;

    typedef struct packed {
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic              use_rs1;
        logic              use_rs2;
    } src_t;

    slot_t            ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
    src_t             exs_q, exs_d;
    logic [2:0]       wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic frz, br_flush, load_use, stall;

    // MEM wins over WB; a load still in MEM has no data yet, and x0 never forwards.
    function automatic logic [1:0] fwd_sel(input logic en, input logic [REG_AW-1:0] rs,
                                           input slot_t mem, input slot_t wb);
        logic [1:0] sel;
        sel = 2'b00;
        if (en && rs != '0) begin
            if (mem.valid && mem.regwrite && !mem.memread && mem.rd == rs) begin
                sel = 2'b10;
            end else if (wb.valid && wb.regwrite && wb.rd == rs) begin
                sel = 2'b01;
            end
        end
        return sel;
    endfunction

    always_comb begin
        frz      = (wait_cnt_q != 3'd0) && !reset_i;
        br_flush = branch_taken_i && !frz && !reset_i;
        load_use = ex_q.valid && ex_q.memread && (ex_q.rd != '0) && id_valid_i &&
                   ((id_use_rs1_i && id_rs1_i == ex_q.rd) ||
                    (id_use_rs2_i && id_rs2_i == ex_q.rd));
        stall    = load_use && !frz && !br_flush && !reset_i;
    end

    assign stall_if_id_o  = stall;
    assign freeze_o       = frz;
    assign flush_if_id_o  = br_flush;
    assign flush_id_ex_o  = br_flush | stall;
    assign flush_ex_mem_o = br_flush;
    assign fwd_a_o        = fwd_sel(ex_q.valid && exs_q.use_rs1 && !reset_i, exs_q.rs1,
                                    mem_q, wb_q);
    assign fwd_b_o        = fwd_sel(ex_q.valid && exs_q.use_rs2 && !reset_i, exs_q.rs2,
                                    mem_q, wb_q);
    assign stall_cnt_o    = stall_cnt_q;
    assign flush_cnt_o    = flush_cnt_q;

    always_comb begin
        ex_d        = ex_q;
        exs_d       = exs_q;
        mem_d       = mem_q;
        wb_d        = wb_q;
        wait_cnt_d  = wait_cnt_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;

        if (frz) begin
            wait_cnt_d = wait_cnt_q - 3'd1;
        end else begin
            wb_d  = mem_q;
            mem_d = br_flush ? slot_t'('0) : ex_q;
            ex_d  = '0;
            exs_d = '0;
            if (id_valid_i && !br_flush && !stall) begin
                ex_d.valid      = 1'b1;
                ex_d.rd         = id_rd_i;
                ex_d.regwrite   = id_regwrite_i;
                ex_d.memread    = id_memread_i;
                exs_d.rs1       = id_rs1_i;
                exs_d.rs2       = id_rs2_i;
                exs_d.use_rs1   = id_use_rs1_i;
                exs_d.use_rs2   = id_use_rs2_i;
            end
            // A load moving into MEM starts the memory wait.
            if (LoadLat != 3'd0 && ex_q.valid && ex_q.memread && !br_flush) begin
                wait_cnt_d = LoadLat;
            end
        end

        if ((stall || frz) && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (br_flush && flush_cnt_q != '1) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ex_q        <= '0;
            exs_q       <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            wait_cnt_q  <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            exs_q       <= exs_d;
            mem_q       <= mem_d;
            wb_q        <= wb_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

endmodule

// File: tb/tb_riscv_hazard_unit.sv
// Scoreboard bench for riscv_hazard_unit: one instance without load latency (16-bit
// counters) and one with LOAD_LATENCY=3 (4-bit counters), sharing the same stimulus.
module tb_riscv_hazard_unit;

    logic       clk;
    logic       reset, id_valid, id_use_rs1, id_use_rs2, id_regwrite, id_memread;
    logic       branch_taken;
    logic [4:0] id_rs1, id_rs2, id_rd;

    logic        stall0, frz0, fif0, fie0, fem0;
    logic [1:0]  fa0, fb0;
    logic [15:0] sc0, fc0;
    logic        stall3, frz3, fif3, fie3, fem3;
    logic [1:0]  fa3, fb3;
    logic [3:0]  sc3, fc3;
    logic [8:0]  obs0, obs3;

    int n_total = 0;
    int n_pass  = 0;

    typedef struct packed {
        logic        rst;
        logic        br;
        logic        v;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        u1;
        logic        u2;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic [8:0]  exp;
        logic        cc;
        logic [15:0] sc;
        logic [15:0] fc;
    } step_t;

    logic [8:0] sb[$];

    riscv_hazard_unit #(.REG_AW(5), .LOAD_LATENCY(0), .CNT_W(16)) u_dut0 (
        .clk_i(clk), .reset_i(reset), .id_valid_i(id_valid), .id_rs1_i(id_rs1),
        .id_rs2_i(id_rs2), .id_use_rs1_i(id_use_rs1), .id_use_rs2_i(id_use_rs2),
        .id_rd_i(id_rd), .id_regwrite_i(id_regwrite), .id_memread_i(id_memread),
        .branch_taken_i(branch_taken), .stall_if_id_o(stall0), .freeze_o(frz0),
        .flush_if_id_o(fif0), .flush_id_ex_o(fie0), .flush_ex_mem_o(fem0),
        .fwd_a_o(fa0), .fwd_b_o(fb0), .stall_cnt_o(sc0), .flush_cnt_o(fc0)
    );

    riscv_hazard_unit #(.REG_AW(5), .LOAD_LATENCY(3), .CNT_W(4)) u_dut3 (
        .clk_i(clk), .reset_i(reset), .id_valid_i(id_valid), .id_rs1_i(id_rs1),
        .id_rs2_i(id_rs2), .id_use_rs1_i(id_use_rs1), .id_use_rs2_i(id_use_rs2),
        .id_rd_i(id_rd), .id_regwrite_i(id_regwrite), .id_memread_i(id_memread),
        .branch_taken_i(branch_taken), .stall_if_id_o(stall3), .freeze_o(frz3),
        .flush_if_id_o(fif3), .flush_id_ex_o(fie3), .flush_ex_mem_o(fem3),
        .fwd_a_o(fa3), .fwd_b_o(fb3), .stall_cnt_o(sc3), .flush_cnt_o(fc3)
    );

    assign obs0 = {stall0, fif0, fie0, fem0, frz0, fa0, fb0};
    assign obs3 = {stall3, fif3, fie3, fem3, frz3, fa3, fb3};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected output vector: {stall, flush_if_id, flush_id_ex, flush_ex_mem, freeze, fa, fb}
    function automatic logic [8:0] ex(int st, int fi, int fe, int fm, int fz, int fa, int fb);
        return {st[0], fi[0], fe[0], fm[0], fz[0], fa[1:0], fb[1:0]};
    endfunction

    function automatic step_t mk(int rst, int br, int v, int rs1, int rs2, int u1, int u2,
                                 int rd, int rw, int mr, logic [8:0] e);
        step_t s;
        s     = '0;
        s.rst = rst[0];
        s.br  = br[0];
        s.v   = v[0];
        s.rs1 = rs1[4:0];
        s.rs2 = rs2[4:0];
        s.u1  = u1[0];
        s.u2  = u2[0];
        s.rd  = rd[4:0];
        s.rw  = rw[0];
        s.mr  = mr[0];
        s.exp = e;
        return s;
    endfunction

    function automatic step_t nop(int br, logic [8:0] e);
        return mk(0, br, 0, 0, 0, 0, 0, 0, 0, 0, e);
    endfunction

    function automatic step_t cnt(step_t s_in, int sc, int fc);
        step_t s;
        s    = s_in;
        s.cc = 1'b1;
        s.sc = sc[15:0];
        s.fc = fc[15:0];
        return s;
    endfunction

    task automatic apply(input step_t s);
        reset        = s.rst;
        branch_taken = s.br;
        id_valid     = s.v;
        id_rs1       = s.rs1;
        id_rs2       = s.rs2;
        id_use_rs1   = s.u1;
        id_use_rs2   = s.u2;
        id_rd        = s.rd;
        id_regwrite  = s.rw;
        id_memread   = s.mr;
    endtask

    task automatic test_reset();
        step_t      st[$];
        logic [8:0] e;
        st.push_back(cnt(mk(1, 1, 1, 5, 5, 1, 1, 5, 1, 1, ex(0, 0, 0, 0, 0, 0, 0)), 0, 0));
        st.push_back(cnt(mk(1, 1, 1, 5, 5, 1, 1, 5, 1, 1, ex(0, 0, 0, 0, 0, 0, 0)), 0, 0));
        foreach (st[i]) begin
            @(negedge clk);
            apply(st[i]);
            sb.push_back(st[i].exp);
            sb.push_back(st[i].exp);
            #1;
            e = sb.pop_front();
            n_total++;
            if (obs0 !== e) $display("FAIL reset[%0d] outputs dut0: got %b want %b", i, obs0, e);
            else n_pass++;
            e = sb.pop_front();
            n_total++;
            if (obs3 !== e) $display("FAIL reset[%0d] outputs dut3: got %b want %b", i, obs3, e);
            else n_pass++;
            n_total++;
            if ({sc0, fc0, sc3, fc3} !== {st[i].sc, st[i].fc, st[i].sc[3:0], st[i].fc[3:0]})
                $display("FAIL reset[%0d] counters: got %0d/%0d %0d/%0d want zero", i,
                         sc0, fc0, sc3, fc3);
            else n_pass++;
        end
    endtask

    task automatic test_load_use();
        step_t      st[$];
        logic [8:0] e;
        // lw x5 ; add x6,x5,x1 stalls once, then reaches EX with the load result in WB
        st.push_back(mk(0, 0, 1, 1, 0, 1, 0, 5, 1, 1, ex(0, 0, 0, 0, 0, 0, 0)));
        st.push_back(cnt(mk(0, 0, 1, 5, 1, 1, 1, 6, 1, 0, ex(1, 0, 1, 0, 0, 0, 0)), 0, 0));
        st.push_back(cnt(mk(0, 0, 1, 5, 1, 1, 1, 6, 1, 0, ex(0, 0, 0, 0, 0, 0, 0)), 1, 0));
        st.push_back(cnt(nop(0, ex(0, 0, 0, 0, 0, 1, 0)), 1, 0));
        foreach (st[i]) begin
            @(negedge clk);
            apply(st[i]);
            sb.push_back(st[i].exp);
            #1;
            e = sb.pop_front();
            n_total++;
            if (obs0 !== e) $display("FAIL load_use[%0d] outputs: got %b want %b", i, obs0, e);
            else n_pass++;
            if (st[i].cc) begin
                n_total++;
                if ({sc0, fc0} !== {st[i].sc, st[i].fc})
                    $display("FAIL load_use[%0d] counters: got %0d/%0d want %0d/%0d", i,
                             sc0, fc0, st[i].sc, st[i].fc);
                else n_pass++;
            end
        end
    endtask

    task automatic test_forward();
        step_t      st[$];
        logic [8:0] e;
        // add x3 ; sub x4,x3,x3 -> MEM forward
        st.push_back(mk(0, 0, 1, 1, 2, 1, 1, 3, 1, 0, ex(0, 0, 0, 0, 0, 0, 0)));
        st.push_back(mk(0, 0, 1, 3, 3, 1, 1, 4, 1, 0, ex(0, 0, 0, 0, 0, 0, 0)));
        st.push_back(nop(0, ex(0, 0, 0, 0, 0, 2, 2)));
        // add x3 ; add x9 ; sub x4,x3,x3 -> WB forward
        st.push_back(mk(0, 0, 1, 1, 2, 1, 1, 3, 1, 0, ex(0, 0, 0, 0, 0, 0, 0)));
        st.push_back(mk(0, 0, 1, 1, 2, 1, 1, 9, 1, 0, ex(0, 0, 0, 0, 0, 0, 0)));
        st.push_back(mk(0, 0, 1, 3, 3, 1, 1, 4, 1, 0, ex(0, 0, 0, 0, 0, 0, 0)));
        st.push_back(nop(0, ex(0, 0, 0, 0, 0, 1, 1)));
        // add x3 ; add x3 ; sub x4,x3,x3 -> both match, MEM wins
        st.push_back(mk(0, 0, 1, 1, 2, 1, 1, 3, 1, 0, ex(0, 0, 0, 0, 0, 0, 0)));
        st.push_back(mk(0, 0, 1, 1, 2, 1, 1, 3, 1, 0, ex(0, 0, 0, 0, 0, 0, 0)));
        st.push_back(mk(0, 0, 1, 3, 3, 1, 1, 4, 1, 0, ex(0, 0, 0, 0, 0, 0, 0)));
        st.push_back(cnt(nop(0, ex(0, 0, 0, 0, 0, 2, 2)), 1, 0));
        foreach (st[i]) begin
            @(negedge clk);
            apply(st[i]);
            sb.push_back(st[i].exp);
            #1;
            e = sb.pop_front();
            n_total++;
            if (obs0 !== e) $display("FAIL forward[%0d] outputs: got %b want %b", i, obs0, e);
            else n_pass++;
            if (st[i].cc) begin
                n_total++;
                if ({sc0, fc0} !== {st[i].sc, st[i].fc})
                    $display("FAIL forward[%0d] counters: got %0d/%0d want %0d/%0d", i,
                             sc0, fc0, st[i].sc, st[i].fc);
                else n_pass++;
            end
        end
    endtask

    task automatic test_x0();
        step_t      st[$];
        logic [8:0] e;
        // two writes to x0, then sub reading x0 twice; then lw x0 followed by a reader of x0
        st.push_back(mk(0, 0, 1, 1, 2, 1, 1, 0, 1, 0, ex(0, 0, 0, 0, 0, 0, 0)));
        st.push_back(mk(0, 0, 1, 1, 2, 1, 1, 0, 1, 0, ex(0, 0, 0, 0, 0, 0, 0)));
        st.push_back(mk(0, 0, 1, 0, 0, 1, 1, 4, 1, 0, ex(0, 0, 0, 0, 0, 0, 0)));
        st.push_back(mk(0, 0, 1, 1, 0, 1, 0, 0, 1, 1, ex(0, 0, 0, 0, 0, 0, 0)));
        st.push_back(mk(0, 0, 1, 0, 0, 1, 1, 6, 1, 0, ex(0, 0, 0, 0, 0, 0, 0)));
        foreach (st[i]) begin
            @(negedge clk);
            apply(st[i]);
            sb.push_back(st[i].exp);
            #1;
            e = sb.pop_front();
            n_total++;
            if (obs0 !== e) $display("FAIL x0[%0d] outputs: got %b want %b", i, obs0, e);
            else n_pass++;
        end
    endtask

    task automatic test_branch();
        step_t      st[$];
        logic [8:0] e;
        // lw x5 ; add x6,x5,x1 with branch_taken: flush beats the load-use stall
        st.push_back(mk(0, 0, 1, 1, 0, 1, 0, 5, 1, 1, ex(0, 0, 0, 0, 0, 0, 0)));
        st.push_back(cnt(mk(0, 1, 1, 5, 1, 1, 1, 6, 1, 0, ex(0, 1, 1, 1, 0, 0, 0)), 1, 0));
        st.push_back(cnt(mk(0, 0, 1, 5, 1, 1, 1, 6, 1, 0, ex(0, 0, 0, 0, 0, 0, 0)), 1, 1));
        st.push_back(cnt(nop(0, ex(0, 0, 0, 0, 0, 0, 0)), 1, 1));
        foreach (st[i]) begin
            @(negedge clk);
            apply(st[i]);
            sb.push_back(st[i].exp);
            #1;
            e = sb.pop_front();
            n_total++;
            if (obs0 !== e) $display("FAIL branch[%0d] outputs: got %b want %b", i, obs0, e);
            else n_pass++;
            if (st[i].cc) begin
                n_total++;
                if ({sc0, fc0} !== {st[i].sc, st[i].fc})
                    $display("FAIL branch[%0d] counters: got %0d/%0d want %0d/%0d", i,
                             sc0, fc0, st[i].sc, st[i].fc);
                else n_pass++;
            end
        end
    endtask

    task automatic test_freeze();
        step_t      st[$];
        logic [8:0] e;
        st.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0)));
        // lw x5 ; lw x8 ; freeze with branch_taken held high ; add x9,x8 stalls afterwards
        st.push_back(cnt(mk(0, 0, 1, 1, 0, 1, 0, 5, 1, 1, ex(0, 0, 0, 0, 0, 0, 0)), 0, 0));
        st.push_back(mk(0, 0, 1, 1, 0, 1, 0, 8, 1, 1, ex(0, 0, 0, 0, 0, 0, 0)));
        st.push_back(nop(1, ex(0, 0, 0, 0, 1, 0, 0)));
        st.push_back(cnt(nop(1, ex(0, 0, 0, 0, 1, 0, 0)), 1, 0));
        st.push_back(cnt(nop(1, ex(0, 0, 0, 0, 1, 0, 0)), 2, 0));
        st.push_back(cnt(mk(0, 0, 1, 8, 1, 1, 1, 9, 1, 0, ex(1, 0, 1, 0, 0, 0, 0)), 3, 0));
        st.push_back(cnt(nop(0, ex(0, 0, 0, 0, 1, 0, 0)), 4, 0));
        // reset in the middle of the second freeze
        st.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0)));
        st.push_back(cnt(nop(0, ex(0, 0, 0, 0, 0, 0, 0)), 0, 0));
        foreach (st[i]) begin
            @(negedge clk);
            apply(st[i]);
            sb.push_back(st[i].exp);
            #1;
            e = sb.pop_front();
            n_total++;
            if (obs3 !== e) $display("FAIL freeze[%0d] outputs: got %b want %b", i, obs3, e);
            else n_pass++;
            if (st[i].cc) begin
                n_total++;
                if ({sc3, fc3} !== {st[i].sc[3:0], st[i].fc[3:0]})
                    $display("FAIL freeze[%0d] counters: got %0d/%0d want %0d/%0d", i,
                             sc3, fc3, st[i].sc, st[i].fc);
                else n_pass++;
            end
        end
    endtask

    // Self-dependent loads: dut0 stalls every other cycle (15 events in 30 cycles);
    // dut3 counts 4 of every 5 cycles (24 events), well past its 4-bit limit.
    task automatic test_saturate();
        @(negedge clk);
        apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, '0));
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            apply(mk(0, 0, 1, 5, 0, 1, 0, 5, 1, 1, '0));
        end
        @(negedge clk);
        apply(nop(0, '0));
        #1;
        n_total++;
        if (sc3 !== 4'hf) $display("FAIL saturate stall_cnt dut3: got %0d want 15", sc3);
        else n_pass++;
        n_total++;
        if (sc0 !== 16'd15) $display("FAIL saturate stall_cnt dut0: got %0d want 15", sc0);
        else n_pass++;
        n_total++;
        if ({fc0, fc3} !== 20'd0)
            $display("FAIL saturate flush_cnt: got %0d/%0d want 0/0", fc0, fc3);
        else n_pass++;
    endtask

    initial begin
        reset        = 1'b1;
        branch_taken = 1'b0;
        id_valid     = 1'b0;
        id_rs1       = '0;
        id_rs2       = '0;
        id_use_rs1   = 1'b0;
        id_use_rs2   = 1'b0;
        id_rd        = '0;
        id_regwrite  = 1'b0;
        id_memread   = 1'b0;
        test_reset();
        test_load_use();
        test_forward();
        test_x0();
        test_branch();
        test_freeze();
        test_saturate();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
